// File: rtl/traffic_pkg.sv
// Shared types and default timing for the junction controller.
//   state_e : controller state encoding (ALLRED, GREEN, YELLOW, PED)
//   DEF_*   : default parameter values (timing in ticks)
//   max_u   : elaboration-time maximum, used for timer sizing
package traffic_pkg;

    typedef enum logic [1:0] {
        ALLRED = 2'd0,
        GREEN  = 2'd1,
        YELLOW = 2'd2,
        PED    = 2'd3
    } state_e;

    localparam int unsigned DEF_PHASES    = 2;
    localparam int unsigned DEF_TICK_DIV  = 50_000_000;
    localparam int unsigned DEF_GREEN_MIN = 5;
    localparam int unsigned DEF_GREEN_MAX = 20;
    localparam int unsigned DEF_YELLOW_T  = 3;
    localparam int unsigned DEF_ALLRED_T  = 2;
    localparam int unsigned DEF_PED_T     = 8;
    localparam int unsigned DEF_PED_FLASH = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_junction_ctrl_tick_gen.sv
// Timing tick divider.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the divider
//   tick : registered one-cycle pulse every TICK_DIV cycles
module tick_gen
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div;

    // Free-running divider; tick is registered off the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            div  <= '0;
            tick <= 1'b0;
        end else if (div == DIV_LAST) begin
            div  <= '0;
            tick <= 1'b1;
        end else begin
            div  <= div + DW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/traffic_junction_ctrl.sv
// N-approach junction controller with actuated green, demand skipping and
// an exclusive all-red pedestrian walk.
//   clk, rst          : clock, synchronous active-high reset
//   det[PHASES]       : vehicle detectors (level)
//   ped_req[PHASES]   : pedestrian buttons (level, latched)
//   car_red/yellow/green[PHASES], ped_red/green[PHASES] : registered lamps
//   cur_phase         : approach owning (or last owning) green
// Optional: define TRAFFIC_PED_FLASH_EN to flash the walk lamp during the
// last PED_FLASH ticks of the walk.
module traffic_junction_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned PHASES    = DEF_PHASES,
    parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
    parameter int unsigned GREEN_MIN = DEF_GREEN_MIN,
    parameter int unsigned GREEN_MAX = DEF_GREEN_MAX,
    parameter int unsigned YELLOW_T  = DEF_YELLOW_T,
    parameter int unsigned ALLRED_T  = DEF_ALLRED_T,
    parameter int unsigned PED_T     = DEF_PED_T,
    parameter int unsigned PED_FLASH = DEF_PED_FLASH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PHASES-1:0]           det,
    input  logic [PHASES-1:0]           ped_req,
    output logic [PHASES-1:0]           car_red,
    output logic [PHASES-1:0]           car_yellow,
    output logic [PHASES-1:0]           car_green,
    output logic [PHASES-1:0]           ped_red,
    output logic [PHASES-1:0]           ped_green,
    output logic [$clog2(PHASES)-1:0]   cur_phase
);

    localparam int unsigned PW    = $clog2(PHASES);
    localparam int unsigned T_MAX = max_u(max_u(ALLRED_T, YELLOW_T), max_u(PED_T, GREEN_MAX));
    // One spare count so the green counter can step past GREEN_MAX before saturating.
    localparam int unsigned TW    = $clog2(T_MAX + 2);

`ifdef TRAFFIC_PED_FLASH_EN
    localparam bit FLASH_EN = 1'b1;
`else
    localparam bit FLASH_EN = 1'b0;
`endif

    // Elaboration-time parameter sanity.
    if (PHASES < 2 || PHASES > 8) begin : g_bad_phases
        $error("traffic_junction_ctrl: PHASES must be 2..8");
    end
    if (GREEN_MAX < GREEN_MIN) begin : g_bad_green
        $error("traffic_junction_ctrl: GREEN_MAX must be >= GREEN_MIN");
    end
    if (FLASH_EN && PED_FLASH >= PED_T) begin : g_bad_flash
        $error("traffic_junction_ctrl: PED_FLASH must be < PED_T");
    end

    logic tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    state_e              state, state_nx;
    logic [PW-1:0]       phase_nx;
    logic [TW-1:0]       timer, timer_nx;
    logic [PHASES-1:0]   dem, dem_nx;
    logic [PHASES-1:0]   pl, pl_nx;
    logic [PHASES-1:0]   served, served_nx;
    logic                last_ped, last_ped_nx;
    logic [PHASES-1:0]   car_red_nx, car_yellow_nx, car_green_nx;
    logic [PHASES-1:0]   ped_red_nx, ped_green_nx;

    logic [PHASES-1:0]   cur_mask, nx_mask, green_mask;
    logic                cur_det, other_dem;
    logic [TW-1:0]       green_cnt;
    logic [PW-1:0]       rr_pick;
    logic                rr_found;
    int unsigned         rr_idx;
    logic                walk_on;
`ifdef TRAFFIC_PED_FLASH_EN
    logic [TW-1:0]       flash_pos;
`endif

    // State, latches and registered lamps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ALLRED;
            cur_phase  <= PW'(PHASES - 1);
            timer      <= TW'(ALLRED_T);
            dem        <= '0;
            pl         <= '0;
            served     <= '0;
            last_ped   <= 1'b0;
            car_red    <= '1;
            car_yellow <= '0;
            car_green  <= '0;
            ped_red    <= '1;
            ped_green  <= '0;
        end else begin
            state      <= state_nx;
            cur_phase  <= phase_nx;
            timer      <= timer_nx;
            dem        <= dem_nx;
            pl         <= pl_nx;
            served     <= served_nx;
            last_ped   <= last_ped_nx;
            car_red    <= car_red_nx;
            car_yellow <= car_yellow_nx;
            car_green  <= car_green_nx;
            ped_red    <= ped_red_nx;
            ped_green  <= ped_green_nx;
        end
    end

    // Next state, latches, round-robin arbiter and lamp decode.
    always_comb begin
        state_nx      = state;
        phase_nx      = cur_phase;
        timer_nx      = timer;
        served_nx     = served;
        last_ped_nx   = last_ped;
        cur_mask      = '0;
        nx_mask       = '0;
        green_mask    = '0;
        rr_pick       = '0;
        rr_found      = 1'b0;
        rr_idx        = 0;
        green_cnt     = timer + TW'(1);
        walk_on       = 1'b1;
        car_red_nx    = '1;
        car_yellow_nx = '0;
        car_green_nx  = '0;
        ped_red_nx    = '1;
        ped_green_nx  = '0;
`ifdef TRAFFIC_PED_FLASH_EN
        flash_pos     = '0;
`endif

        for (int p = 0; p < int'(PHASES); p++) begin
            cur_mask[p] = (cur_phase == PW'(p));
        end
        if (state == GREEN) begin
            green_mask = cur_mask;
        end
        cur_det   = |(det & cur_mask);
        other_dem = (|(dem & ~cur_mask)) | (|pl);

        // First demanding approach after cur_phase; the final iteration wraps
        // back to cur_phase itself. No demand at all falls through to cur+1.
        for (int i = 1; i <= int'(PHASES); i++) begin
            rr_idx = (int'(cur_phase) + i) % int'(PHASES);
            if (!rr_found && dem[rr_idx]) begin
                rr_found = 1'b1;
                rr_pick  = PW'(rr_idx);
            end
        end
        if (!rr_found) begin
            rr_pick = (int'(cur_phase) + 1 >= int'(PHASES)) ? '0 : cur_phase + PW'(1);
        end

        case (state)
            ALLRED: begin
                if (tick) begin
                    if (timer <= TW'(1)) begin
                        if ((|pl) && !last_ped) begin
                            state_nx  = PED;
                            timer_nx  = TW'(PED_T);
                            // Include same-cycle presses: the latch clears on this edge.
                            served_nx = pl | ped_req;
                        end else begin
                            state_nx = GREEN;
                            phase_nx = rr_pick;
                            timer_nx = '0;
                        end
                    end else begin
                        timer_nx = timer - TW'(1);
                    end
                end
            end
            GREEN: begin
                if (tick) begin
                    if (other_dem &&
                        ((green_cnt >= TW'(GREEN_MIN) && !cur_det) ||
                         green_cnt >= TW'(GREEN_MAX))) begin
                        state_nx = YELLOW;
                        timer_nx = TW'(YELLOW_T);
                    end else if (green_cnt >= TW'(GREEN_MAX)) begin
                        timer_nx = TW'(GREEN_MAX);
                    end else begin
                        timer_nx = green_cnt;
                    end
                end
            end
            YELLOW: begin
                if (tick) begin
                    if (timer <= TW'(1)) begin
                        state_nx    = ALLRED;
                        timer_nx    = TW'(ALLRED_T);
                        last_ped_nx = 1'b0;
                    end else begin
                        timer_nx = timer - TW'(1);
                    end
                end
            end
            PED: begin
                if (tick) begin
                    if (timer <= TW'(1)) begin
                        state_nx    = ALLRED;
                        timer_nx    = TW'(ALLRED_T);
                        last_ped_nx = 1'b1;
                    end else begin
                        timer_nx = timer - TW'(1);
                    end
                end
            end
            default: begin
                state_nx = ALLRED;
                timer_nx = TW'(ALLRED_T);
            end
        endcase

        for (int p = 0; p < int'(PHASES); p++) begin
            nx_mask[p] = (phase_nx == PW'(p));
        end

        // Demand is only taken from approaches not currently green; entering
        // green for an approach consumes its demand.
        dem_nx = dem | (det & ~green_mask);
        if (state_nx == GREEN && state != GREEN) begin
            dem_nx = dem_nx & ~nx_mask;
        end
        pl_nx = (state_nx == PED && state != PED) ? '0 : (pl | ped_req);

        // Lamps decoded from the next state so they change on the transition edge.
        case (state_nx)
            GREEN: begin
                car_green_nx = nx_mask;
                car_red_nx   = ~nx_mask;
            end
            YELLOW: begin
                car_yellow_nx = nx_mask;
                car_red_nx    = ~nx_mask;
            end
            PED: begin
`ifdef TRAFFIC_PED_FLASH_EN
                // Flash phase 0 is low, then alternates each tick.
                if (timer_nx <= TW'(PED_FLASH)) begin
                    flash_pos = TW'(PED_FLASH) - timer_nx;
                    walk_on   = flash_pos[0];
                end
`endif
                ped_green_nx = walk_on ? served_nx : '0;
                ped_red_nx   = ~served_nx;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_junction_ctrl.sv
// Directed, table-driven bench for traffic_junction_ctrl (3 approaches,
// 4-cycle tick) plus a hand-written held-ped-button sequence.
module tb_traffic_junction_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] det;
    logic [2:0] ped_req;
    logic [2:0] car_red, car_yellow, car_green, ped_red, ped_green;
    logic [1:0] cur_phase;

`ifdef TRAFFIC_PED_FLASH_EN
    localparam logic [2:0] FL_LOW = 3'b000;
`else
    localparam logic [2:0] FL_LOW = 3'b010;
`endif

    traffic_junction_ctrl #(
        .PHASES    (3),
        .TICK_DIV  (4),
        .GREEN_MIN (2),
        .GREEN_MAX (5),
        .YELLOW_T  (1),
        .ALLRED_T  (1),
        .PED_T     (3),
        .PED_FLASH (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .det        (det),
        .ped_req    (ped_req),
        .car_red    (car_red),
        .car_yellow (car_yellow),
        .car_green  (car_green),
        .ped_red    (ped_red),
        .ped_green  (ped_green),
        .cur_phase  (cur_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] det;
        logic [2:0] ped;
        int         n;
        logic [2:0] red, yel, grn, pgrn, pred;
        logic [1:0] ph;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    function automatic void add(input logic r, input logic [2:0] d, input logic [2:0] pq,
                                input int n, input logic [2:0] red, input logic [2:0] yel,
                                input logic [2:0] grn, input logic [2:0] pgrn,
                                input logic [2:0] pred, input logic [1:0] ph);
        vec_t v;
        v.rst = r; v.det = d; v.ped = pq; v.n = n;
        v.red = red; v.yel = yel; v.grn = grn; v.pgrn = pgrn; v.pred = pred; v.ph = ph;
        tbl.push_back(v);
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input int id, input logic [2:0] red, input logic [2:0] yel,
                         input logic [2:0] grn, input logic [2:0] pgrn,
                         input logic [2:0] pred, input logic [1:0] ph);
        checks++;
        if ({car_red, car_yellow, car_green, ped_green, ped_red, cur_phase} !==
            {red, yel, grn, pgrn, pred, ph}) begin
            errors++;
            $display("FAIL step%0d: got red=%b yel=%b grn=%b pgrn=%b pred=%b ph=%0d, want red=%b yel=%b grn=%b pgrn=%b pred=%b ph=%0d",
                     id, car_red, car_yellow, car_green, ped_green, ped_red, cur_phase,
                     red, yel, grn, pgrn, pred, ph);
        end
    endtask

    // Per-cycle lamp sanity: one car lamp per approach, never both ped lamps.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int p = 0; p < 3; p++) begin
                checks++;
                if (({1'b0, car_red[p]} + {1'b0, car_yellow[p]} + {1'b0, car_green[p]}) != 2'd1 ||
                    (ped_red[p] && ped_green[p])) begin
                    errors++;
                    $display("FAIL lamp_excl p%0d: got r/y/g=%b%b%b pr/pg=%b%b, want one car lamp and not both ped lamps",
                             p, car_red[p], car_yellow[p], car_green[p], ped_red[p], ped_green[p]);
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        det     = '0;
        ped_req = '0;

        // A: reset release, no inputs -> phase 0 green after one tick, rests.
        add(1, 3'b000, 3'b000,  2, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 2);
        add(0, 3'b000, 3'b000,  4, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 2);
        add(0, 3'b000, 3'b000,  1, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);
        add(0, 3'b000, 3'b000, 40, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);
        // B: det[2] pulse -> gap-out after GREEN_MIN, phase 1 skipped.
        add(1, 3'b000, 3'b000,  2, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 2);
        add(0, 3'b000, 3'b000,  5, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);
        add(0, 3'b100, 3'b000,  1, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);
        add(0, 3'b000, 3'b000,  6, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);
        add(0, 3'b000, 3'b000,  1, 3'b110, 3'b001, 3'b000, 3'b000, 3'b111, 0);
        add(0, 3'b000, 3'b000,  3, 3'b110, 3'b001, 3'b000, 3'b000, 3'b111, 0);
        add(0, 3'b000, 3'b000,  1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 0);
        add(0, 3'b000, 3'b000,  4, 3'b011, 3'b000, 3'b100, 3'b000, 3'b111, 2);
        add(0, 3'b000, 3'b000, 20, 3'b011, 3'b000, 3'b100, 3'b000, 3'b111, 2);
        // C: det[0] and det[1] held -> max-out at 5 ticks, then phase 1.
        add(1, 3'b011, 3'b000,  2, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 2);
        add(0, 3'b011, 3'b000,  5, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);
        add(0, 3'b011, 3'b000, 19, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);
        add(0, 3'b011, 3'b000,  1, 3'b110, 3'b001, 3'b000, 3'b000, 3'b111, 0);
        add(0, 3'b011, 3'b000,  4, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 0);
        add(0, 3'b011, 3'b000,  4, 3'b101, 3'b000, 3'b010, 3'b000, 3'b111, 1);
        add(0, 3'b011, 3'b000, 19, 3'b101, 3'b000, 3'b010, 3'b000, 3'b111, 1);
        add(0, 3'b011, 3'b000,  1, 3'b101, 3'b010, 3'b000, 3'b000, 3'b111, 1);
        // D: ped_req[1] pulse -> yellow, all-red, 3-tick walk, all-red, phase 1.
        add(1, 3'b000, 3'b000,  2, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 2);
        add(0, 3'b000, 3'b000,  5, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);
        add(0, 3'b000, 3'b010,  1, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);
        add(0, 3'b000, 3'b000,  6, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);
        add(0, 3'b000, 3'b000,  1, 3'b110, 3'b001, 3'b000, 3'b000, 3'b111, 0);
        add(0, 3'b000, 3'b000,  4, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 0);
        add(0, 3'b000, 3'b000,  4, 3'b111, 3'b000, 3'b000, 3'b010, 3'b101, 0);
        add(0, 3'b000, 3'b000,  3, 3'b111, 3'b000, 3'b000, 3'b010, 3'b101, 0);
        add(0, 3'b000, 3'b000,  1, 3'b111, 3'b000, 3'b000, FL_LOW, 3'b101, 0);
        add(0, 3'b000, 3'b000,  4, 3'b111, 3'b000, 3'b000, 3'b010, 3'b101, 0);
        add(0, 3'b000, 3'b000,  3, 3'b111, 3'b000, 3'b000, 3'b010, 3'b101, 0);
        add(0, 3'b000, 3'b000,  1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 0);
        add(0, 3'b000, 3'b000,  4, 3'b101, 3'b000, 3'b010, 3'b000, 3'b111, 1);
        // E: reset mid-yellow with demand and ped latched -> latches cleared.
        add(1, 3'b000, 3'b000,  2, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 2);
        add(0, 3'b000, 3'b000,  5, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);
        add(0, 3'b100, 3'b100,  1, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);
        add(0, 3'b000, 3'b000,  6, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);
        add(0, 3'b000, 3'b000,  1, 3'b110, 3'b001, 3'b000, 3'b000, 3'b111, 0);
        add(1, 3'b000, 3'b000,  1, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 2);
        add(0, 3'b000, 3'b000,  5, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);
        add(0, 3'b000, 3'b000, 20, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);

        foreach (tbl[i]) begin
            rst     = tbl[i].rst;
            det     = tbl[i].det;
            ped_req = tbl[i].ped;
            cyc(tbl[i].n);
            check(i, tbl[i].red, tbl[i].yel, tbl[i].grn, tbl[i].pgrn, tbl[i].pred, tbl[i].ph);
            mon_en = 1'b1;
        end

        // F: button held from reset -> walk first, no back-to-back walk,
        // re-latched request served after one green, release ends it.
        rst = 1'b1; det = '0; ped_req = 3'b010;
        cyc(2);  check(100, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 2);
        rst = 1'b0;
        cyc(4);  check(101, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 2);
        cyc(1);  check(102, 3'b111, 3'b000, 3'b000, 3'b010, 3'b101, 2);
        cyc(4);  check(103, 3'b111, 3'b000, 3'b000, FL_LOW, 3'b101, 2);
        cyc(4);  check(104, 3'b111, 3'b000, 3'b000, 3'b010, 3'b101, 2);
        cyc(4);  check(105, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 2);
        cyc(4);  check(106, 3'b110, 3'b000, 3'b001, 3'b000, 3'b111, 0);
        cyc(8);  check(107, 3'b110, 3'b001, 3'b000, 3'b000, 3'b111, 0);
        cyc(4);  check(108, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 0);
        cyc(4);  check(109, 3'b111, 3'b000, 3'b000, 3'b010, 3'b101, 0);
        ped_req = 3'b000;
        cyc(12); check(110, 3'b111, 3'b000, 3'b000, 3'b000, 3'b111, 0);
        cyc(4);  check(111, 3'b101, 3'b000, 3'b010, 3'b000, 3'b111, 1);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_junction_ctrl.md
# traffic_junction_ctrl

Parametrised N-approach junction controller, the next generation of the single-road `traffic_light` block. It sequences car lights for `PHASES` conflicting approaches with vehicle-actuated green extension and demand-based phase skipping. It also serves an exclusive all-red pedestrian walk for latched button requests. It sits under `top` in place of `traffic_light`, driven by the board clock and the synchronised reset.

## Interface
Parameters:
- `PHASES`, 2: number of approaches (2..8).
- `TICK_DIV`, 50_000_000: clock cycles per timing tick (≥1).
- `GREEN_MIN`, 5: minimum green, ticks (≥1).
- `GREEN_MAX`, 20: maximum green under competing demand, ticks (≥ `GREEN_MIN`).
- `YELLOW_T`, 3: yellow duration, ticks (≥1).
- `ALLRED_T`, 2: all-red clearance, ticks (≥1).
- `PED_T`, 8: pedestrian walk duration, ticks (≥1).
- `PED_FLASH`, 3: final walk ticks with flashing ped green (macro only, < `PED_T`).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `det`  in  `PHASES`  vehicle detector per approach, level.
- `ped_req`  in  `PHASES`  pedestrian button per approach, level.
- `car_red` / `car_yellow` / `car_green`  out  `PHASES` each  car lamps.
- `ped_red` / `ped_green`  out  `PHASES` each  pedestrian lamps.
- `cur_phase`  out  `$clog2(PHASES)`  approach currently owning (or last owning) green.

## Operation
- States: `ALLRED`, `GREEN`, `YELLOW`, `PED`. All lamp outputs are registered. Exactly one of red/yellow/green is set per approach in every cycle.
- Reset: state `ALLRED` with its timer loaded to `ALLRED_T`. `cur_phase` = `PHASES-1`. All `car_red`=1, `car_yellow`=`car_green`=0, `ped_red`=all 1, `ped_green`=0. Demand and ped latches are cleared and the tick divider is cleared.
- Demand latch `dem[p]`: set when `det[p]`=1 while p is not green. Cleared on entry to `GREEN` for p.
- Ped latch `pl[p]`: set when `ped_req[p]`=1 in any state. Cleared on entry to `PED`. A request held through entry re-latches on the next cycle.
- `GREEN` (approach `cur_phase`): the timer counts ticks from 0.
  - Before `GREEN_MIN`, it always holds.
  - After `GREEN_MIN`, with no other demand (`dem` of other approaches=0 and `pl`=0), it rests in green indefinitely.
  - With other demand and `det[cur_phase]`=0, it goes to `YELLOW` (gap-out).
  - With other demand and `det[cur_phase]`=1, it holds until `GREEN_MAX` ticks, then goes to `YELLOW` (max-out).
- `YELLOW`: lasts `YELLOW_T` ticks, then `ALLRED`.
- `ALLRED`: lasts `ALLRED_T` ticks. Exit:
  - If any `pl` is set and the previous state was not `PED`, go to `PED`.
  - Otherwise go to `GREEN` for the next approach, searching round-robin from `cur_phase+1` for the first with `dem` set. With no demand anywhere, pick `cur_phase+1` mod `PHASES`.
- `PED`: all car lamps red. `ped_green[p]`=1 for every p latched at entry and `ped_red` for the others. Lasts `PED_T` ticks, then `ALLRED` (ped clearance) with all `ped_red`.
- Simultaneous events: requests arriving in the same cycle as a state exit are latched and never lost. Round-robin prevents starvation; each approach with demand gets green within `PHASES-1` other greens.
- `rst` mid-operation returns to the reset state on the next edge regardless of current state. No yellow is inserted.

## Timing
- Tick: a single-cycle pulse when the divider reaches `TICK_DIV-1`. The timer advances only on ticks.
- A state transition is registered on the cycle after the tick that completes its duration. Lamps change in that same edge.
- The first green after reset (approach 0) appears `ALLRED_T` ticks after `rst` deasserts.
- Input-to-latch latency is one cycle. Inputs are assumed already synchronised by `top`.

## Configuration
- `TRAFFIC_PED_FLASH_EN` defined: during the last `PED_FLASH` ticks of `PED`, `ped_green` of the served approaches toggles on every tick, starting low on the first flash tick. `ped_red` stays 0 while flashing.
- Not defined: `ped_green` is steady for all of `PED_T`, and `PED_FLASH` is ignored.

## Structure
- Shared package `traffic_pkg`: the state enum (`ALLRED`, `GREEN`, `YELLOW`, `PED`) and the default timing constants.
- Sub-module `tick_gen` (parameter `TICK_DIV`; ports `clk`, `rst`, `tick`). The controller's FSM, latches and round-robin arbiter stay in one module.

## Test plan
All scenarios use `PHASES`=3, `TICK_DIV`=4, `GREEN_MIN`=2, `GREEN_MAX`=5, `YELLOW_T`=1, `ALLRED_T`=1, `PED_T`=3.
- Reset release, no inputs -> `car_green`=3'b001 after 1 tick; rests there indefinitely with all other lamps red.
- `det`=3'b100 pulsed for 1 cycle while phase 0 is green and `det[0]`=0 -> after `GREEN_MIN`: yellow 1 tick, all-red 1 tick, `car_green`=3'b100, `cur_phase`=2 (phase 1 skipped).
- `det[0]` held 1 and `det[1]` held 1 -> phase 0 max-outs at 5 ticks of green, then phase 1 green.
- `ped_req`=3'b010 pulse during green -> after yellow/all-red: all `car_red`, `ped_green`=3'b010 for 3 ticks, all-red, then next green.
- `rst` asserted mid-`YELLOW` -> next cycle all `car_red`, `ped_red`, `cur_phase`=2, latches cleared.
- With `TRAFFIC_PED_FLASH_EN`, `PED_FLASH`=2 -> `ped_green` steady for 1 tick, then 0,1 across the last 2 ticks.
